// File: rtl/lab5_mcore_mem_req_arb.sv
// ---------------------------------------------------------------------------
// lab5_mcore_mem_req_arb
//
// Memory request arbiter and response router for the multicore. It merges
// N per-core request streams into one cache/memory port using round-robin
// arbitration. It then routes each response back to its core using a port id
// held in the top bits of the opaque field. Each direction has one registered
// stage.
//
// Parameters
//   p_num_ports     number of requester ports N (2..16)
//   p_opaque_nbits  opaque field width O (>= clog2(N))
//   p_addr_nbits    address field width A
//   p_data_nbits    data field width D (multiple of 8)
//
// Ports
//   clk           clock; all state changes on the rising edge
//   reset         asynchronous reset, active low (0 = in reset)
//   in_req_msg    N packed requests; port i occupies [i*REQ +: REQ]
//   in_req_val    per-port request valid
//   in_req_rdy    per-port request ready (one-hot grant, or all zero)
//   out_req_msg   merged request; opaque top bits hold the source port
//   out_req_val   merged request valid
//   out_req_rdy   cache/memory ready
//   in_resp_msg   response from cache/memory
//   in_resp_val   response valid
//   in_resp_rdy   response ready
//   out_resp_msg  N copies of the response; opaque top bits cleared
//   out_resp_val  per-port response valid (one-hot or zero)
//   out_resp_rdy  per-port response ready
//   route_err     sticky flag; set when a response names a port id >= N
// ---------------------------------------------------------------------------
module lab5_mcore_mem_req_arb #(
   parameter int p_num_ports    = 4,
   parameter int p_opaque_nbits = 8,
   parameter int p_addr_nbits   = 32,
   parameter int p_data_nbits   = 32,
   localparam int I   = $clog2(p_num_ports),
   localparam int L   = $clog2(p_data_nbits/8),
   localparam int REQ = 3 + p_opaque_nbits + p_addr_nbits + L + p_data_nbits,
   localparam int RSP = 3 + p_opaque_nbits + 2 + L + p_data_nbits
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [p_num_ports*REQ-1:0] in_req_msg,
   input  logic [p_num_ports-1:0]     in_req_val,
   output logic [p_num_ports-1:0]     in_req_rdy,
   output logic [REQ-1:0]             out_req_msg,
   output logic                       out_req_val,
   input  logic                       out_req_rdy,
   input  logic [RSP-1:0]             in_resp_msg,
   input  logic                       in_resp_val,
   output logic                       in_resp_rdy,
   output logic [p_num_ports*RSP-1:0] out_resp_msg,
   output logic [p_num_ports-1:0]     out_resp_val,
   input  logic [p_num_ports-1:0]     out_resp_rdy,
   output logic                       route_err
);

   // The port id sits in the most significant I bits of the opaque field.
   // The opaque field starts just below the 3-bit type field.
   localparam int REQ_ID_MSB = REQ - 4;
   localparam int RSP_ID_MSB = RSP - 4;

   // Write the granted port index into the opaque top bits of a request.
   function automatic logic [REQ-1:0] tag_req(input logic [REQ-1:0] msg,
                                              input logic [I-1:0]   id);
      logic [REQ-1:0] t;
      t = msg;
      t[REQ_ID_MSB -: I] = id;
      return t;
   endfunction

   // Clear the routing bits before a response returns to its requester.
   function automatic logic [RSP-1:0] strip_rsp(input logic [RSP-1:0] msg);
      logic [RSP-1:0] t;
      t = msg;
      t[RSP_ID_MSB -: I] = '0;
      return t;
   endfunction

   // ---------------- request stage p0: round-robin grant ----------------
   logic [I-1:0]     rr_ptr;
   logic [I-1:0]     gnt_idx_p0;
   logic             gnt_vld_p0;
   logic [I-1:0]     rr_next_p0;
   logic             can_acc_p0;
   logic             req_acc_p0;
   logic [REQ-1:0]   gnt_msg_p0;
   logic [I:0]       cand;

   logic [REQ-1:0]   req_msg_p1;
   logic             req_vld_p1;

   // Scan the ports starting at rr_ptr and wrap modulo N. For N that is
   // not a power of two, an explicit subtract is needed.
   always_comb begin
      gnt_vld_p0 = 1'b0;
      gnt_idx_p0 = '0;
      cand       = '0;
      for (int k = 0; k < p_num_ports; k++) begin
         cand = {1'b0, rr_ptr} + (I+1)'(k);
         if (cand >= (I+1)'(p_num_ports))
            cand = cand - (I+1)'(p_num_ports);
         if (!gnt_vld_p0 && in_req_val[cand[I-1:0]]) begin
            gnt_vld_p0 = 1'b1;
            gnt_idx_p0 = cand[I-1:0];
         end
      end
   end

   assign rr_next_p0 = (gnt_idx_p0 == I'(p_num_ports - 1)) ? '0 : gnt_idx_p0 + 1'b1;
   assign can_acc_p0 = !req_vld_p1 || out_req_rdy;
   assign req_acc_p0 = reset && gnt_vld_p0 && can_acc_p0;
   assign gnt_msg_p0 = tag_req(in_req_msg[int'(gnt_idx_p0)*REQ +: REQ], gnt_idx_p0);
   assign in_req_rdy = req_acc_p0 ? (p_num_ports'(1) << gnt_idx_p0) : '0;

   // ---------------- request stage p1: output register ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         req_vld_p1 <= 1'b0;
         rr_ptr     <= '0;
      end else if (req_acc_p0) begin
         req_vld_p1 <= 1'b1;
         rr_ptr     <= rr_next_p0;
      end else if (out_req_rdy) begin
         req_vld_p1 <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (req_acc_p0)
         req_msg_p1 <= gnt_msg_p0;
   end

   assign out_req_val = req_vld_p1;
   assign out_req_msg = req_msg_p1;

   // ---------------- response stage p0: accept / route check ----------------
   logic [I-1:0]   rsp_id_p0;
   logic           rsp_bad_p0;
   logic           rsp_xfer_p0;
   logic           rsp_load_p0;
   logic [RSP-1:0] rsp_msg_p1;
   logic           rsp_vld_p1;
   logic [I-1:0]   rsp_id_p1;
   logic           rsp_drain_p1;

   assign rsp_id_p0    = in_resp_msg[RSP_ID_MSB -: I];
   assign rsp_bad_p0   = ({1'b0, rsp_id_p0} >= (I+1)'(p_num_ports));
   assign rsp_id_p1    = rsp_msg_p1[RSP_ID_MSB -: I];
   assign rsp_drain_p1 = rsp_vld_p1 && out_resp_rdy[rsp_id_p1];
   assign in_resp_rdy  = reset && (!rsp_vld_p1 || out_resp_rdy[rsp_id_p1]);
   assign rsp_xfer_p0  = in_resp_val && in_resp_rdy;
   // A response with an unroutable id is consumed but never stored.
   assign rsp_load_p0  = rsp_xfer_p0 && !rsp_bad_p0;

   // ---------------- response stage p1: output register ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rsp_vld_p1 <= 1'b0;
         route_err  <= 1'b0;
      end else begin
         if (rsp_load_p0)
            rsp_vld_p1 <= 1'b1;
         else if (rsp_drain_p1)
            rsp_vld_p1 <= 1'b0;
         if (rsp_xfer_p0 && rsp_bad_p0)
            route_err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rsp_load_p0)
         rsp_msg_p1 <= in_resp_msg;
   end

   assign out_resp_val = rsp_vld_p1 ? (p_num_ports'(1) << rsp_id_p1) : '0;
   assign out_resp_msg = {p_num_ports{strip_rsp(rsp_msg_p1)}};

endmodule

// File: tb/tb_lab5_mcore_mem_req_arb.sv
module tb_lab5_mcore_mem_req_arb;
   localparam int N   = 4;
   localparam int REQ = 77;
   localparam int RSP = 47;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [N*REQ-1:0] in_req_msg = '0;
   logic [N-1:0]     in_req_val = '0;
   logic [N-1:0]     in_req_rdy;
   logic [REQ-1:0]   out_req_msg;
   logic             out_req_val;
   logic             out_req_rdy = 1'b0;
   logic [RSP-1:0]   in_resp_msg = '0;
   logic             in_resp_val = 1'b0;
   logic             in_resp_rdy;
   logic [N*RSP-1:0] out_resp_msg;
   logic [N-1:0]     out_resp_val;
   logic [N-1:0]     out_resp_rdy = '0;
   logic             route_err;

   // N=3 instance, used to exercise unroutable response ids
   logic [3*REQ-1:0] req3_msg = '0;
   logic [2:0]       req3_val = '0;
   logic [2:0]       req3_rdy;
   logic [REQ-1:0]   oreq3_msg;
   logic             oreq3_val;
   logic [RSP-1:0]   resp3_msg = '0;
   logic             resp3_val = 1'b0;
   logic             resp3_rdy;
   logic [3*RSP-1:0] oresp3_msg;
   logic [2:0]       oresp3_val;
   logic             route_err3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lab5_mcore_mem_req_arb #(.p_num_ports(4)) dut (
      .clk(clk), .reset(rst_n),
      .in_req_msg(in_req_msg), .in_req_val(in_req_val), .in_req_rdy(in_req_rdy),
      .out_req_msg(out_req_msg), .out_req_val(out_req_val), .out_req_rdy(out_req_rdy),
      .in_resp_msg(in_resp_msg), .in_resp_val(in_resp_val), .in_resp_rdy(in_resp_rdy),
      .out_resp_msg(out_resp_msg), .out_resp_val(out_resp_val), .out_resp_rdy(out_resp_rdy),
      .route_err(route_err));

   lab5_mcore_mem_req_arb #(.p_num_ports(3)) dut3 (
      .clk(clk), .reset(rst_n),
      .in_req_msg(req3_msg), .in_req_val(req3_val), .in_req_rdy(req3_rdy),
      .out_req_msg(oreq3_msg), .out_req_val(oreq3_val), .out_req_rdy(1'b1),
      .in_resp_msg(resp3_msg), .in_resp_val(resp3_val), .in_resp_rdy(resp3_rdy),
      .out_resp_msg(oresp3_msg), .out_resp_val(oresp3_val), .out_resp_rdy(3'b111),
      .route_err(route_err3));

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Default request from port p: opaque 0x10+p, addr 0x1000*(p+1), data 0xD0+p
   function automatic logic [REQ-1:0] req_msg(input int p);
      logic [7:0]  o;
      logic [31:0] a;
      logic [31:0] d;
      o = 8'h10 + 8'(p);
      a = 32'h1000 * 32'(p + 1);
      d = 32'hD0 + 32'(p);
      return {3'd0, o, a, 2'd0, d};
   endfunction

   // The same request as it should appear on the merged port
   function automatic logic [REQ-1:0] exp_req(input int p);
      logic [7:0]  o;
      logic [31:0] a;
      logic [31:0] d;
      o = (8'(p) << 6) | (8'h10 + 8'(p));
      a = 32'h1000 * 32'(p + 1);
      d = 32'hD0 + 32'(p);
      return {3'd0, o, a, 2'd0, d};
   endfunction

   function automatic logic [RSP-1:0] rsp(input logic [7:0] opq, input logic [31:0] d);
      return {3'd0, opq, 2'd0, 2'd0, d};
   endfunction

   typedef struct {
      logic [3:0] val;
      logic       ordy;
      logic [3:0] exp_rdy;
      int         exp_out;   // port whose request sits in ReqQ, -1 for empty
   } vec_t;

   vec_t vecs[15];

   initial begin
      vecs[0]  = '{4'b0000, 1'b1, 4'b0000, -1};
      vecs[1]  = '{4'b0100, 1'b0, 4'b0100, -1};
      vecs[2]  = '{4'b0000, 1'b0, 4'b0000,  2};
      vecs[3]  = '{4'b1111, 1'b0, 4'b0000,  2};
      vecs[4]  = '{4'b1111, 1'b1, 4'b1000,  2};
      vecs[5]  = '{4'b1111, 1'b1, 4'b0001,  3};
      vecs[6]  = '{4'b1111, 1'b1, 4'b0010,  0};
      vecs[7]  = '{4'b1111, 1'b1, 4'b0100,  1};
      vecs[8]  = '{4'b0011, 1'b1, 4'b0001,  2};
      vecs[9]  = '{4'b0011, 1'b1, 4'b0010,  0};
      vecs[10] = '{4'b0000, 1'b1, 4'b0000,  1};
      vecs[11] = '{4'b1001, 1'b1, 4'b1000, -1};
      vecs[12] = '{4'b0000, 1'b0, 4'b0000,  3};
      vecs[13] = '{4'b0000, 1'b1, 4'b0000,  3};
      vecs[14] = '{4'b0000, 1'b1, 4'b0000, -1};

      for (int p = 0; p < N; p++) in_req_msg[p*REQ +: REQ] = req_msg(p);

      // reset state
      repeat (2) @(negedge clk);
      in_req_val = 4'b1111;
      #1;
      check("rst_out_req_val", 96'(out_req_val), 96'(0));
      check("rst_in_req_rdy", 96'(in_req_rdy), 96'(0));
      check("rst_out_resp_val", 96'(out_resp_val), 96'(0));
      check("rst_in_resp_rdy", 96'(in_resp_rdy), 96'(0));
      check("rst_route_err", 96'(route_err), 96'(0));
      in_req_val = '0;
      @(negedge clk);
      rst_n = 1'b1;

      // table-driven request path
      for (int i = 0; i < 15; i++) begin
         in_req_val  = vecs[i].val;
         out_req_rdy = vecs[i].ordy;
         #1;
         check($sformatf("vec%0d_in_req_rdy", i), 96'(in_req_rdy), 96'(vecs[i].exp_rdy));
         check($sformatf("vec%0d_out_req_val", i), 96'(out_req_val), 96'(vecs[i].exp_out >= 0));
         if (vecs[i].exp_out >= 0)
            check($sformatf("vec%0d_out_req_msg", i), 96'(out_req_msg), 96'(exp_req(vecs[i].exp_out)));
         @(negedge clk);
      end

      // backpressure: hold ReqQ full for 5 cycles, then release
      in_req_val = 4'b1111;
      out_req_rdy = 1'b0;
      #1 check("bp_first_grant", 96'(in_req_rdy), 96'(4'b0001));
      @(negedge clk);
      for (int c = 0; c < 5; c++) begin
         #1;
         check("bp_in_req_rdy", 96'(in_req_rdy), 96'(0));
         check("bp_out_req_msg", 96'(out_req_msg), 96'(exp_req(0)));
         check("bp_out_req_val", 96'(out_req_val), 96'(1));
         @(negedge clk);
      end
      out_req_rdy = 1'b1;
      #1 check("bp_release_grant", 96'(in_req_rdy), 96'(4'b0010));
      @(negedge clk);
      in_req_val = '0;
      #1 check("bp_next_msg", 96'(out_req_msg), 96'(exp_req(1)));
      @(negedge clk);
      #1 check("bp_drained", 96'(out_req_val), 96'(0));

      // single requester tagging and response routing
      in_req_msg[2*REQ +: REQ] = {3'd0, 8'h05, 32'h1000, 2'd0, 32'h0};
      out_req_rdy = 1'b0;
      in_req_val = 4'b0100;
      #1;
      check("t1_not_yet_visible", 96'(out_req_val), 96'(0));
      check("t1_grant", 96'(in_req_rdy), 96'(4'b0100));
      @(negedge clk);
      in_req_val = '0;
      #1;
      check("t1_out_val", 96'(out_req_val), 96'(1));
      check("t1_out_opaque", 96'(out_req_msg[73:66]), 96'(8'h85));
      check("t1_out_addr", 96'(out_req_msg[65:34]), 96'(32'h1000));
      out_req_rdy = 1'b1;
      @(negedge clk);
      in_resp_msg = rsp(8'h85, 32'hCAFE);
      in_resp_val = 1'b1;
      out_resp_rdy = '0;
      #1 check("t1_resp_rdy", 96'(in_resp_rdy), 96'(1));
      @(negedge clk);
      in_resp_val = 1'b0;
      #1;
      check("t1_resp_val", 96'(out_resp_val), 96'(4'b0100));
      check("t1_resp_msg", 96'(out_resp_msg[2*RSP +: RSP]), 96'(rsp(8'h05, 32'hCAFE)));
      out_resp_rdy = 4'b1111;
      @(negedge clk);
      #1 check("t1_resp_drained", 96'(out_resp_val), 96'(0));

      // response backpressure on port 1, then drain + load together
      out_resp_rdy = '0;
      in_resp_msg = rsp(8'h41, 32'h1);
      in_resp_val = 1'b1;
      #1 check("t4_first_rdy", 96'(in_resp_rdy), 96'(1));
      @(negedge clk);
      in_resp_msg = rsp(8'hC7, 32'h2);
      for (int c = 0; c < 2; c++) begin
         #1;
         check("t4_blocked_rdy", 96'(in_resp_rdy), 96'(0));
         check("t4_port1_val", 96'(out_resp_val), 96'(4'b0010));
         @(negedge clk);
      end
      out_resp_rdy = 4'b0010;
      #1 check("t4_unblocked_rdy", 96'(in_resp_rdy), 96'(1));
      @(negedge clk);
      in_resp_val = 1'b0;
      out_resp_rdy = '0;
      #1;
      check("t4_next_val", 96'(out_resp_val), 96'(4'b1000));
      check("t4_next_msg", 96'(out_resp_msg[3*RSP +: RSP]), 96'(rsp(8'h07, 32'h2)));
      out_resp_rdy = 4'b1111;
      @(negedge clk);

      // N=3: unroutable id is swallowed and flagged
      resp3_msg = rsp(8'hC3, 32'h5);
      resp3_val = 1'b1;
      #1;
      check("t5_rdy", 96'(resp3_rdy), 96'(1));
      check("t5_err_before", 96'(route_err3), 96'(0));
      @(negedge clk);
      resp3_val = 1'b0;
      #1;
      check("t5_no_val", 96'(oresp3_val), 96'(0));
      check("t5_err_set", 96'(route_err3), 96'(1));
      check("t5_err_n4_clear", 96'(route_err), 96'(0));
      resp3_msg = rsp(8'h80, 32'h6);
      resp3_val = 1'b1;
      @(negedge clk);
      resp3_val = 1'b0;
      #1;
      check("t5_port2_val", 96'(oresp3_val), 96'(3'b100));
      check("t5_err_sticky", 96'(route_err3), 96'(1));
      @(negedge clk);

      // async reset mid-stream with both queues full
      out_req_rdy = 1'b0;
      in_req_val = 4'b0010;
      out_resp_rdy = '0;
      in_resp_msg = rsp(8'h00, 32'h9);
      in_resp_val = 1'b1;
      @(negedge clk);
      in_resp_val = 1'b0;
      #1;
      check("t6_req_full", 96'(out_req_val), 96'(1));
      check("t6_resp_full", 96'(out_resp_val), 96'(4'b0001));
      in_req_val = 4'b1111;
      out_req_rdy = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      check("t6_rst_req_val", 96'(out_req_val), 96'(0));
      check("t6_rst_resp_val", 96'(out_resp_val), 96'(0));
      check("t6_rst_in_req_rdy", 96'(in_req_rdy), 96'(0));
      check("t6_rst_in_resp_rdy", 96'(in_resp_rdy), 96'(0));
      check("t6_rst_err3", 96'(route_err3), 96'(0));
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("t6_grant_port0", 96'(in_req_rdy), 96'(4'b0001));
      @(negedge clk);
      in_req_val = '0;
      #1 check("t6_out_port0", 96'(out_req_msg), 96'(exp_req(0)));
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Safety net so the run always ends.
   initial begin
      #100000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end
endmodule
